reg_id_ex: RTL and testbench
============================

Name: reg_id_ex

Overview:
- ID/EX pipeline register sitting directly downstream of the instruction decoder (control decode) stage.
- Latches the decoder's control bundle plus operand/immediate data into the EX stage, and computes the EX destination register.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch/jump flush.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- WTG_OP_W, `WTG_OP_BIT, width of op_wtg
- ALU_OP_W, `ALU_OP_BIT, width of op_alu
- DM_OP_W, `DM_OP_BIT, width of op_datamem
- REQW_W, `MUX_RF_REQW_BIT, width of regfile write-address mux select
- DATAW_W, `MUX_RF_DATAW_BIT, width of regfile write-data mux select
- DATAY_W, `MUX_ALU_DATAY_BIT, width of ALU Y mux select

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  downstream (EX/MEM) cannot accept; hold stage
- flush_in  in  1  taken branch/jump resolved; kill ID content
- id_valid  in  1  ID stage holds a real instruction
- id_op_wtg, id_w_en_regfile, id_op_alu, id_op_datamem, id_w_en_datamem, id_syscall_en, id_mux_regfile_req_w, id_mux_regfile_data_w, id_mux_alu_data_y, id_is_jump, id_is_branch  in  per parameter/1  decoder outputs
- id_rs, id_rt, id_rd  in  5 each  instruction register fields
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
- id_pc4  in  32  PC+4
- id_rf_a, id_rf_b  in  32 each  register file read data
- id_imm16  in  16  immediate field; id_shamt in 5
- ex_*  out  same widths  registered copies of every id_* field above except uses_*; ex_valid  out  1
- ex_dst  out  5  registered destination: rt / rd / 31 per id_mux_regfile_req_w (`MUX_RF_REQW_RT/RD/31)
- stall_up  out  1  combinational; IF and ID must hold
- bubble_cnt  out  16  saturating count of inserted bubbles

Behaviour:
- Reset:
  - All ex_* outputs, ex_valid, ex_dst and bubble_cnt become 0 on the first rising edge with rst=1.
  - rst overrides every other input.
- hazard (combinational) = ex_valid & id_valid & ex_w_en_regfile & (ex_mux_regfile_data_w == `MUX_RF_DATAW_DM) & (ex_dst != 0) & ((id_uses_rs & id_rs == ex_dst) | (id_uses_rt & id_rt == ex_dst)).
- stall_up = ~flush_in & (stall_in | hazard).
- Per-edge priority:
  - 1) rst.
  - 2) flush_in: load a bubble. stall_in is ignored; the flush wins.
  - 3) stall_in: hold all registers unchanged.
  - 4) hazard: load a bubble and increment bubble_cnt.
  - 5) Otherwise load the ID inputs; ex_valid = id_valid.
- Bubble:
  - ex_valid = 0.
  - All ex_* fields and ex_dst are 0, so w_en_regfile, w_en_datamem, syscall_en, is_jump and is_branch are all 0.
- An ID input with id_valid=0 is loaded as a bubble; this does not count toward bubble_cnt.
- bubble_cnt:
  - Increments only on hazard bubbles.
  - Saturates at 16'hFFFF and does not wrap.
  - A flush bubble does not count.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble; the cycle after the bubble, hazard is 0 because ex_valid=0.
- ex_dst is computed at load time from the ID fields. Any unlisted req_w encoding yields 0.
- No combinational path from id_* inputs to ex_* outputs.
- stall_up depends on id_* inputs only through hazard.

Test Plan:
- Reset mid-stream: load an addu, then assert rst for 1 cycle -> all ex_* = 0, ex_valid = 0, bubble_cnt = 0 on the next edge.
- Load-use: lw $8 in EX (data_w = DM, dst = 8), ID addu $9,$8,$10 with uses_rs=1 -> stall_up=1 for exactly 1 cycle, then ex_valid=0 and bubble_cnt=1, and the addu enters EX on the following edge.
- No false hazard:
  - lw $0 in EX with an ID reader of $0 -> stall_up=0.
  - addu $8 in EX (data_w = ALU) with an ID reader of $8 -> stall_up=0.
- Simultaneous events: stall_in=1 with flush_in=1 -> stall_up=0 and the next edge yields a bubble. stall_in=1 alone for 3 cycles -> ex_* unchanged throughout and stall_up=1.
- Destination mux: jal (req_w = 31) -> ex_dst = 31. addu rd=5 -> ex_dst = 5. addi rt=7 -> ex_dst = 7.
- Saturation: drive 65540 consecutive load-use hazards -> bubble_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/reg_id_ex.sv
// ID/EX pipeline register: latches the decoded control bundle and operands
// into EX, detects load-use hazards, and keeps a saturating bubble counter.
module reg_id_ex #(
  parameter int WTG_OP_W = 3,
  parameter int ALU_OP_W = 4,
  parameter int DM_OP_W  = 3,
  parameter int REQW_W   = 2,
  parameter int DATAW_W  = 2,
  parameter int DATAY_W  = 2,
  parameter logic [REQW_W-1:0]  MUX_RF_REQW_RT  = REQW_W'(0),
  parameter logic [REQW_W-1:0]  MUX_RF_REQW_RD  = REQW_W'(1),
  parameter logic [REQW_W-1:0]  MUX_RF_REQW_31  = REQW_W'(2),
  parameter logic [DATAW_W-1:0] MUX_RF_DATAW_DM = DATAW_W'(1),
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                flush_in,
  input  logic                id_valid,
  input  logic [WTG_OP_W-1:0] id_op_wtg,
  input  logic                id_w_en_regfile,
  input  logic [ALU_OP_W-1:0] id_op_alu,
  input  logic [DM_OP_W-1:0]  id_op_datamem,
  input  logic                id_w_en_datamem,
  input  logic                id_syscall_en,
  input  logic [REQW_W-1:0]   id_mux_regfile_req_w,
  input  logic [DATAW_W-1:0]  id_mux_regfile_data_w,
  input  logic [DATAY_W-1:0]  id_mux_alu_data_y,
  input  logic                id_is_jump,
  input  logic                id_is_branch,
  input  logic [4:0]          id_rs,
  input  logic [4:0]          id_rt,
  input  logic [4:0]          id_rd,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [31:0]         id_pc4,
  input  logic [31:0]         id_rf_a,
  input  logic [31:0]         id_rf_b,
  input  logic [15:0]         id_imm16,
  input  logic [4:0]          id_shamt,
  output logic                ex_valid,
  output logic [WTG_OP_W-1:0] ex_op_wtg,
  output logic                ex_w_en_regfile,
  output logic [ALU_OP_W-1:0] ex_op_alu,
  output logic [DM_OP_W-1:0]  ex_op_datamem,
  output logic                ex_w_en_datamem,
  output logic                ex_syscall_en,
  output logic [REQW_W-1:0]   ex_mux_regfile_req_w,
  output logic [DATAW_W-1:0]  ex_mux_regfile_data_w,
  output logic [DATAY_W-1:0]  ex_mux_alu_data_y,
  output logic                ex_is_jump,
  output logic                ex_is_branch,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd,
  output logic [31:0]         ex_pc4,
  output logic [31:0]         ex_rf_a,
  output logic [31:0]         ex_rf_b,
  output logic [15:0]         ex_imm16,
  output logic [4:0]          ex_shamt,
  output logic [4:0]          ex_dst,
  output logic                stall_up,
  output logic [CNT_W-1:0]    bubble_cnt
);

  // Everything held in the EX stage; an all-zero value is a bubble.
  typedef struct packed {
    logic                valid;
    logic [WTG_OP_W-1:0] op_wtg;
    logic                w_en_regfile;
    logic [ALU_OP_W-1:0] op_alu;
    logic [DM_OP_W-1:0]  op_datamem;
    logic                w_en_datamem;
    logic                syscall_en;
    logic [REQW_W-1:0]   mux_regfile_req_w;
    logic [DATAW_W-1:0]  mux_regfile_data_w;
    logic [DATAY_W-1:0]  mux_alu_data_y;
    logic                is_jump;
    logic                is_branch;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [31:0]         pc4;
    logic [31:0]         rf_a;
    logic [31:0]         rf_b;
    logic [15:0]         imm16;
    logic [4:0]          shamt;
    logic [4:0]          dst;
  } stage_t;

  stage_t          stage_q, stage_d;
  stage_t          id_stage;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            hazard;
  logic [4:0]      id_dst;

  // Assemble the ID bundle, resolving the destination register at load time.
  always_comb begin
    id_dst = 5'd0;
    if (id_mux_regfile_req_w == MUX_RF_REQW_RT)      id_dst = id_rt;
    else if (id_mux_regfile_req_w == MUX_RF_REQW_RD) id_dst = id_rd;
    else if (id_mux_regfile_req_w == MUX_RF_REQW_31) id_dst = 5'd31;

    id_stage                    = '0;
    id_stage.valid              = 1'b1;
    id_stage.op_wtg             = id_op_wtg;
    id_stage.w_en_regfile       = id_w_en_regfile;
    id_stage.op_alu             = id_op_alu;
    id_stage.op_datamem         = id_op_datamem;
    id_stage.w_en_datamem       = id_w_en_datamem;
    id_stage.syscall_en         = id_syscall_en;
    id_stage.mux_regfile_req_w  = id_mux_regfile_req_w;
    id_stage.mux_regfile_data_w = id_mux_regfile_data_w;
    id_stage.mux_alu_data_y     = id_mux_alu_data_y;
    id_stage.is_jump            = id_is_jump;
    id_stage.is_branch          = id_is_branch;
    id_stage.rs                 = id_rs;
    id_stage.rt                 = id_rt;
    id_stage.rd                 = id_rd;
    id_stage.pc4                = id_pc4;
    id_stage.rf_a               = id_rf_a;
    id_stage.rf_b               = id_rf_b;
    id_stage.imm16              = id_imm16;
    id_stage.shamt              = id_shamt;
    id_stage.dst                = id_dst;
  end

  // Load-use detection: a load in EX whose result the ID instruction needs now.
  always_comb begin
    hazard = stage_q.valid & id_valid & stage_q.w_en_regfile &
             (stage_q.mux_regfile_data_w == MUX_RF_DATAW_DM) &
             (stage_q.dst != 5'd0) &
             ((id_uses_rs & (id_rs == stage_q.dst)) |
              (id_uses_rt & (id_rt == stage_q.dst)));
    stall_up = ~flush_in & (stall_in | hazard);
  end

  // Next-state selection: flush beats stall, stall beats hazard, hazard beats load.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush_in) begin
      stage_d = '0;
    end else if (stall_in) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (!id_valid) begin
      stage_d = '0;
    end else begin
      stage_d = id_stage;
    end
  end

  // Stage register and bubble counter, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs come straight from the stage register.
  always_comb begin
    ex_valid              = stage_q.valid;
    ex_op_wtg             = stage_q.op_wtg;
    ex_w_en_regfile       = stage_q.w_en_regfile;
    ex_op_alu             = stage_q.op_alu;
    ex_op_datamem         = stage_q.op_datamem;
    ex_w_en_datamem       = stage_q.w_en_datamem;
    ex_syscall_en         = stage_q.syscall_en;
    ex_mux_regfile_req_w  = stage_q.mux_regfile_req_w;
    ex_mux_regfile_data_w = stage_q.mux_regfile_data_w;
    ex_mux_alu_data_y     = stage_q.mux_alu_data_y;
    ex_is_jump            = stage_q.is_jump;
    ex_is_branch          = stage_q.is_branch;
    ex_rs                 = stage_q.rs;
    ex_rt                 = stage_q.rt;
    ex_rd                 = stage_q.rd;
    ex_pc4                = stage_q.pc4;
    ex_rf_a               = stage_q.rf_a;
    ex_rf_b               = stage_q.rf_b;
    ex_imm16              = stage_q.imm16;
    ex_shamt              = stage_q.shamt;
    ex_dst                = stage_q.dst;
    bubble_cnt            = cnt_q;
  end

endmodule

// File: tb/tb_reg_id_ex.sv
// Bench for reg_id_ex: directed instruction sequences, a behavioural model of
// the EX stage checked every cycle, and hand-computed literal expectations.
module tb_reg_id_ex;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [2:0]  op_wtg;
    logic        w_en_rf;
    logic [3:0]  op_alu;
    logic [2:0]  op_dm;
    logic        w_en_dm;
    logic        syscall;
    logic [1:0]  req_w;
    logic [1:0]  data_w;
    logic [1:0]  data_y;
    logic        is_jump;
    logic        is_branch;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic [31:0] pc4;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [15:0] imm16;
    logic [4:0]  shamt;
  } instr_t;

  logic clk, rst, stall_in, flush_in;
  instr_t id;

  logic              ex_valid, ex_w_en_regfile, ex_w_en_datamem, ex_syscall_en;
  logic              ex_is_jump, ex_is_branch, stall_up;
  logic [2:0]        ex_op_wtg, ex_op_datamem;
  logic [3:0]        ex_op_alu;
  logic [1:0]        ex_mux_regfile_req_w, ex_mux_regfile_data_w, ex_mux_alu_data_y;
  logic [4:0]        ex_rs, ex_rt, ex_rd, ex_shamt, ex_dst;
  logic [31:0]       ex_pc4, ex_rf_a, ex_rf_b;
  logic [15:0]       ex_imm16;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en;
  int pc_seed = 32'h0040_0000;

  reg_id_ex #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id.valid), .id_op_wtg(id.op_wtg), .id_w_en_regfile(id.w_en_rf),
    .id_op_alu(id.op_alu), .id_op_datamem(id.op_dm), .id_w_en_datamem(id.w_en_dm),
    .id_syscall_en(id.syscall), .id_mux_regfile_req_w(id.req_w),
    .id_mux_regfile_data_w(id.data_w), .id_mux_alu_data_y(id.data_y),
    .id_is_jump(id.is_jump), .id_is_branch(id.is_branch),
    .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .id_uses_rs(id.uses_rs), .id_uses_rt(id.uses_rt),
    .id_pc4(id.pc4), .id_rf_a(id.rf_a), .id_rf_b(id.rf_b),
    .id_imm16(id.imm16), .id_shamt(id.shamt),
    .ex_valid(ex_valid), .ex_op_wtg(ex_op_wtg), .ex_w_en_regfile(ex_w_en_regfile),
    .ex_op_alu(ex_op_alu), .ex_op_datamem(ex_op_datamem),
    .ex_w_en_datamem(ex_w_en_datamem), .ex_syscall_en(ex_syscall_en),
    .ex_mux_regfile_req_w(ex_mux_regfile_req_w),
    .ex_mux_regfile_data_w(ex_mux_regfile_data_w),
    .ex_mux_alu_data_y(ex_mux_alu_data_y),
    .ex_is_jump(ex_is_jump), .ex_is_branch(ex_is_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_pc4(ex_pc4), .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
    .ex_imm16(ex_imm16), .ex_shamt(ex_shamt), .ex_dst(ex_dst),
    .stall_up(stall_up), .bubble_cnt(bubble_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The model remembers which instruction sits in EX (or none) and the
  // number of load-use bubbles so far.
  instr_t     mdl_ex;
  logic [4:0] mdl_dst;
  int         mdl_cnt;

  // Destination register an instruction will write.
  function automatic logic [4:0] dest_of(instr_t x);
    case (x.req_w)
      2'd0:    return x.rt;
      2'd1:    return x.rd;
      2'd2:    return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  // True when EX holds a real load into a nonzero register that ID reads.
  function automatic logic load_use(instr_t ex, logic [4:0] ex_dest, instr_t nxt);
    logic is_load, reads_it;
    is_load  = ex.valid && ex.w_en_rf && (ex.data_w == 2'd1) && (ex_dest != 5'd0);
    reads_it = (nxt.uses_rs && nxt.rs == ex_dest) || (nxt.uses_rt && nxt.rt == ex_dest);
    return nxt.valid && is_load && reads_it;
  endfunction

  // Model update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      mdl_ex  <= '0;
      mdl_dst <= 5'd0;
      mdl_cnt <= 0;
    end else if (flush_in) begin
      mdl_ex  <= '0;
      mdl_dst <= 5'd0;
    end else if (stall_in) begin
      mdl_ex  <= mdl_ex;
    end else if (load_use(mdl_ex, mdl_dst, id)) begin
      mdl_ex  <= '0;
      mdl_dst <= 5'd0;
      mdl_cnt <= (mdl_cnt < CNT_MAX) ? mdl_cnt + 1 : CNT_MAX;
    end else if (!id.valid) begin
      mdl_ex  <= '0;
      mdl_dst <= 5'd0;
    end else begin
      mdl_ex  <= id;
      mdl_dst <= dest_of(id);
    end
  end

  // Every-cycle comparison of DUT against model, away from the active edge.
  always @(negedge clk) begin
    logic [157:0] dut_img, mdl_img;
    logic         exp_stall;
    if (chk_en) begin
      dut_img = {ex_op_wtg, ex_w_en_regfile, ex_op_alu, ex_op_datamem,
                 ex_w_en_datamem, ex_syscall_en, ex_mux_regfile_req_w,
                 ex_mux_regfile_data_w, ex_mux_alu_data_y, ex_is_jump,
                 ex_is_branch, ex_rs, ex_rt, ex_rd, ex_pc4, ex_rf_a, ex_rf_b,
                 ex_imm16, ex_shamt, ex_dst};
      mdl_img = {mdl_ex.op_wtg, mdl_ex.w_en_rf, mdl_ex.op_alu, mdl_ex.op_dm,
                 mdl_ex.w_en_dm, mdl_ex.syscall, mdl_ex.req_w, mdl_ex.data_w,
                 mdl_ex.data_y, mdl_ex.is_jump, mdl_ex.is_branch, mdl_ex.rs,
                 mdl_ex.rt, mdl_ex.rd, mdl_ex.pc4, mdl_ex.rf_a, mdl_ex.rf_b,
                 mdl_ex.imm16, mdl_ex.shamt, mdl_dst};
      exp_stall = !flush_in && (stall_in || load_use(mdl_ex, mdl_dst, id));
      n_vec++;
      if (dut_img !== mdl_img) begin
        n_err++;
        $display("[TB] FAIL model_ex_fields @%0t: got %h, expected %h", $time, dut_img, mdl_img);
      end
      n_vec++;
      if (ex_valid !== mdl_ex.valid) begin
        n_err++;
        $display("[TB] FAIL model_ex_valid @%0t: got %b, expected %b", $time, ex_valid, mdl_ex.valid);
      end
      n_vec++;
      if (stall_up !== exp_stall) begin
        n_err++;
        $display("[TB] FAIL model_stall_up @%0t: got %b, expected %b", $time, stall_up, exp_stall);
      end
      n_vec++;
      if (int'(bubble_cnt) != mdl_cnt || $isunknown(bubble_cnt)) begin
        n_err++;
        $display("[TB] FAIL model_bubble_cnt @%0t: got %0d, expected %0d", $time, bubble_cnt, mdl_cnt);
      end
    end
  end

  // ---------------- instruction builders ----------------
  function automatic instr_t base_instr();
    instr_t x;
    x         = '0;
    x.valid   = 1'b1;
    pc_seed   = pc_seed + 4;
    x.pc4     = pc_seed;
    x.rf_a    = $urandom;
    x.rf_b    = $urandom;
    x.op_wtg  = 3'($urandom_range(1, 7));
    x.shamt   = 5'($urandom_range(0, 31));
    return x;
  endfunction

  function automatic instr_t mk_addu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    instr_t x = base_instr();
    x.op_alu = 4'h2; x.w_en_rf = 1'b1; x.req_w = 2'd1; x.data_w = 2'd0;
    x.rs = rs; x.rt = rt; x.rd = rd; x.uses_rs = 1'b1; x.uses_rt = 1'b1;
    x.imm16 = {rd, 5'd0, 6'h21};
    return x;
  endfunction

  function automatic instr_t mk_lw(logic [4:0] rt, logic [4:0] rs);
    instr_t x = base_instr();
    x.op_alu = 4'h1; x.op_dm = 3'd1; x.w_en_rf = 1'b1; x.req_w = 2'd0;
    x.data_w = 2'd1; x.data_y = 2'd1; x.rs = rs; x.rt = rt; x.rd = 5'd17;
    x.uses_rs = 1'b1; x.imm16 = 16'h0010;
    return x;
  endfunction

  function automatic instr_t mk_addi(logic [4:0] rt, logic [4:0] rs, logic [15:0] imm);
    instr_t x = base_instr();
    x.op_alu = 4'h1; x.w_en_rf = 1'b1; x.req_w = 2'd0; x.data_w = 2'd0;
    x.data_y = 2'd1; x.rs = rs; x.rt = rt; x.rd = 5'd22; x.uses_rs = 1'b1;
    x.imm16 = imm;
    return x;
  endfunction

  function automatic instr_t mk_jal();
    instr_t x = base_instr();
    x.w_en_rf = 1'b1; x.req_w = 2'd2; x.data_w = 2'd2; x.is_jump = 1'b1;
    x.rs = 5'd3; x.rt = 5'd4; x.rd = 5'd6; x.imm16 = 16'h1234;
    return x;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(instr_t x, logic stall, logic flush);
    id       = x;
    stall_in = stall;
    flush_in = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    instr_t x;
    chk_en = 1'b0;
    rst = 1'b1;
    applyStimulus(mk_addu(5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
    tick();
    tick();
    chk_en = 1'b1;
    checkOutput("reset_ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset_bubble_cnt", 32'(bubble_cnt), 32'd0);
    checkOutput("reset_ex_dst", 32'(ex_dst), 32'd0);
    rst = 1'b0;

    $display("[TB] reset mid-stream");
    applyStimulus(mk_addu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    tick();
    checkOutput("addu_dst", 32'(ex_dst), 32'd5);
    checkOutput("addu_valid", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_valid", 32'(ex_valid), 32'd0);
    checkOutput("midreset_rf_a", ex_rf_a, 32'd0);
    checkOutput("midreset_cnt", 32'(bubble_cnt), 32'd0);

    $display("[TB] load-use on rs");
    applyStimulus(mk_lw(5'd8, 5'd29), 1'b0, 1'b0);
    tick();
    applyStimulus(mk_addu(5'd9, 5'd8, 5'd10), 1'b0, 1'b0);
    checkOutput("lu_stall_up", 32'(stall_up), 32'd1);
    tick();
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_bubble_wen", 32'(ex_w_en_regfile), 32'd0);
    checkOutput("lu_cnt", 32'(bubble_cnt), 32'd1);
    checkOutput("lu_stall_released", 32'(stall_up), 32'd0);
    tick();
    checkOutput("lu_addu_dst", 32'(ex_dst), 32'd9);
    checkOutput("lu_addu_valid", 32'(ex_valid), 32'd1);

    $display("[TB] load-use on rt");
    applyStimulus(mk_lw(5'd8, 5'd29), 1'b0, 1'b0);
    tick();
    x = mk_addu(5'd11, 5'd1, 5'd8);
    x.uses_rs = 1'b0;
    applyStimulus(x, 1'b0, 1'b0);
    checkOutput("lu_rt_stall_up", 32'(stall_up), 32'd1);
    tick();
    checkOutput("lu_rt_cnt", 32'(bubble_cnt), 32'd2);
    tick();

    $display("[TB] flush beats hazard");
    applyStimulus(mk_lw(5'd8, 5'd29), 1'b0, 1'b0);
    tick();
    applyStimulus(mk_addu(5'd9, 5'd8, 5'd10), 1'b0, 1'b1);
    checkOutput("flush_hz_stall_up", 32'(stall_up), 32'd0);
    tick();
    checkOutput("flush_hz_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_hz_cnt", 32'(bubble_cnt), 32'd2);

    $display("[TB] no false hazards");
    applyStimulus(mk_lw(5'd0, 5'd29), 1'b0, 1'b0);
    tick();
    applyStimulus(mk_addu(5'd3, 5'd0, 5'd0), 1'b0, 1'b0);
    checkOutput("lw_r0_stall_up", 32'(stall_up), 32'd0);
    applyStimulus(mk_addu(5'd8, 5'd1, 5'd2), 1'b0, 1'b0);
    tick();
    applyStimulus(mk_addu(5'd4, 5'd8, 5'd8), 1'b0, 1'b0);
    checkOutput("alu_src_stall_up", 32'(stall_up), 32'd0);

    $display("[TB] stall with flush");
    applyStimulus(mk_addi(5'd12, 5'd1, 16'h0003), 1'b1, 1'b1);
    checkOutput("stall_flush_stall_up", 32'(stall_up), 32'd0);
    tick();
    checkOutput("stall_flush_valid", 32'(ex_valid), 32'd0);

    $display("[TB] destination mux");
    applyStimulus(mk_jal(), 1'b0, 1'b0);
    tick();
    checkOutput("jal_dst", 32'(ex_dst), 32'd31);
    checkOutput("jal_is_jump", 32'(ex_is_jump), 32'd1);
    applyStimulus(mk_addi(5'd7, 5'd2, 16'hFFF0), 1'b0, 1'b0);
    tick();
    checkOutput("addi_dst", 32'(ex_dst), 32'd7);
    checkOutput("addi_imm", 32'(ex_imm16), 32'h0000FFF0);
    x = mk_addu(5'd14, 5'd1, 5'd2);
    x.req_w = 2'd3;
    applyStimulus(x, 1'b0, 1'b0);
    tick();
    checkOutput("unlisted_reqw_dst", 32'(ex_dst), 32'd0);
    applyStimulus(mk_addi(5'd7, 5'd2, 16'h0042), 1'b0, 1'b0);
    tick();

    $display("[TB] stall for three cycles");
    applyStimulus(mk_addu(5'd12, 5'd3, 5'd4), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall3_stall_up", 32'(stall_up), 32'd1);
      tick();
      checkOutput("stall3_dst_held", 32'(ex_dst), 32'd7);
      checkOutput("stall3_imm_held", 32'(ex_imm16), 32'h00000042);
    end
    stall_in = 1'b0;

    $display("[TB] invalid ID slot");
    x = mk_addu(5'd13, 5'd3, 5'd4);
    x.valid = 1'b0;
    applyStimulus(x, 1'b0, 1'b0);
    tick();
    checkOutput("invalid_id_valid", 32'(ex_valid), 32'd0);
    checkOutput("invalid_id_dst", 32'(ex_dst), 32'd0);
    checkOutput("invalid_id_cnt", 32'(bubble_cnt), 32'd2);

    $display("[TB] bubble counter saturation");
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      applyStimulus(mk_lw(5'd8, 5'd29), 1'b0, 1'b0);
      tick();
      applyStimulus(mk_addu(5'd9, 5'd8, 5'd10), 1'b0, 1'b0);
      tick();
    end
    checkOutput("sat_cnt", 32'(bubble_cnt), 32'(CNT_MAX));
    applyStimulus(mk_lw(5'd8, 5'd29), 1'b0, 1'b0);
    tick();
    applyStimulus(mk_addu(5'd9, 5'd8, 5'd10), 1'b0, 1'b0);
    tick();
    checkOutput("sat_cnt_hold", 32'(bubble_cnt), 32'(CNT_MAX));

    applyStimulus('0, 1'b0, 1'b0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
